// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared state, opcode and datapath-select encodings for the
//               multicycle controller and the ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

   localparam logic [3:0] C_ST_IDLE   = 4'd0;
   localparam logic [3:0] C_ST_FETCH  = 4'd1;
   localparam logic [3:0] C_ST_DECODE = 4'd2;
   localparam logic [3:0] C_ST_MEMADR = 4'd3;
   localparam logic [3:0] C_ST_MEMRD  = 4'd4;
   localparam logic [3:0] C_ST_MEMWB  = 4'd5;
   localparam logic [3:0] C_ST_MEMWR  = 4'd6;
   localparam logic [3:0] C_ST_EXEC   = 4'd7;
   localparam logic [3:0] C_ST_ALUWB  = 4'd8;
   localparam logic [3:0] C_ST_BRANCH = 4'd9;
   localparam logic [3:0] C_ST_JUMP   = 4'd10;
   localparam logic [3:0] C_ST_ADDIEX = 4'd11;
   localparam logic [3:0] C_ST_ADDIWB = 4'd12;
   localparam logic [3:0] C_ST_ILLEG  = 4'd13;

   localparam logic [5:0] C_OP_RTYPE = 6'b000000;
   localparam logic [5:0] C_OP_LW    = 6'b100011;
   localparam logic [5:0] C_OP_SW    = 6'b101011;
   localparam logic [5:0] C_OP_BEQ   = 6'b000100;
   localparam logic [5:0] C_OP_J     = 6'b000010;
   localparam logic [5:0] C_OP_ADDI  = 6'b001000;

   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] C_SRCB_REG    = 2'b00;
   localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
   localparam logic [1:0] C_SRCB_IMM    = 2'b10;
   localparam logic [1:0] C_SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
   localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       illegal;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module      : multicycle_ctrl_decode
// Description : Combinational state-to-control-vector decode for the
//               multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       mem_ready_i,
   input  logic       zero_i,
   output ctrl_t      ctrl_o
);

   logic w_pc_write;
   logic w_pc_write_cond;

   always_comb begin
      ctrl_o          = '0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      case (state_i)
         C_ST_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = C_SRCB_FOUR;
            ctrl_o.ir_write  = mem_ready_i;
            w_pc_write       = mem_ready_i;
         end
         C_ST_DECODE: ctrl_o.alu_src_b = C_SRCB_IMMSH2;
         C_ST_MEMADR, C_ST_ADDIEX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = C_SRCB_IMM;
         end
         C_ST_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         C_ST_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         C_ST_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
         end
         C_ST_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = C_ALUOP_FUNCT;
         end
         C_ST_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         C_ST_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = C_ALUOP_SUB;
            ctrl_o.pc_src    = C_PCSRC_ALUOUT;
            w_pc_write_cond  = 1'b1;
         end
         C_ST_JUMP: begin
            ctrl_o.pc_src = C_PCSRC_JUMP;
            w_pc_write    = 1'b1;
         end
         C_ST_ADDIWB: ctrl_o.reg_write = 1'b1;
         C_ST_ILLEG:  ctrl_o.illegal   = 1'b1;
         default: ;
      endcase
      ctrl_o.pc_en = w_pc_write | (w_pc_write_cond & zero_i);
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle CPU control FSM with retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   import multicycle_ctrl_pkg::*;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_retire;
   ctrl_t            w_ctrl;

   always_comb begin
      state_d = state_q;
      case (state_q)
         C_ST_IDLE:   state_d = C_ST_FETCH;
         C_ST_FETCH:  if (mem_ready) state_d = C_ST_DECODE;
         C_ST_DECODE: begin
            case (opcode)
               C_OP_LW, C_OP_SW: state_d = C_ST_MEMADR;
               C_OP_RTYPE:       state_d = C_ST_EXEC;
               C_OP_BEQ:         state_d = C_ST_BRANCH;
               C_OP_J:           state_d = C_ST_JUMP;
               C_OP_ADDI:        state_d = C_ST_ADDIEX;
               default:          state_d = C_ST_ILLEG;
            endcase
         end
         // Opcode stays valid from the instruction register through MEMADR.
         C_ST_MEMADR: state_d = (opcode == C_OP_SW) ? C_ST_MEMWR : C_ST_MEMRD;
         C_ST_MEMRD:  if (mem_ready) state_d = C_ST_MEMWB;
         C_ST_MEMWR:  if (mem_ready) state_d = C_ST_FETCH;
         C_ST_EXEC:   state_d = C_ST_ALUWB;
         C_ST_ADDIEX: state_d = C_ST_ADDIWB;
         C_ST_MEMWB, C_ST_ALUWB, C_ST_BRANCH,
         C_ST_JUMP, C_ST_ADDIWB, C_ST_ILLEG: state_d = C_ST_FETCH;
         default:     state_d = C_ST_IDLE;
      endcase
   end

   // ILLEG returns to FETCH without retiring an instruction.
   always_comb begin
      w_retire = 1'b0;
      case (state_q)
         C_ST_MEMWB, C_ST_ALUWB, C_ST_BRANCH,
         C_ST_JUMP, C_ST_ADDIWB: w_retire = 1'b1;
         C_ST_MEMWR:             w_retire = mem_ready;
         default:                w_retire = 1'b0;
      endcase
   end

   assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, w_retire};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= C_ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   multicycle_ctrl_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .zero_i      (zero),
      .ctrl_o      (w_ctrl)
   );

   assign alu_op     = w_ctrl.alu_op;
   assign alu_src_a  = w_ctrl.alu_src_a;
   assign alu_src_b  = w_ctrl.alu_src_b;
   assign iord       = w_ctrl.iord;
   assign mem_read   = w_ctrl.mem_read;
   assign mem_write  = w_ctrl.mem_write;
   assign ir_write   = w_ctrl.ir_write;
   assign reg_dst    = w_ctrl.reg_dst;
   assign mem_to_reg = w_ctrl.mem_to_reg;
   assign reg_write  = w_ctrl.reg_write;
   assign pc_src     = w_ctrl.pc_src;
   assign pc_en      = w_ctrl.pc_en;
   assign illegal    = w_ctrl.illegal;
   assign instr_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic [1:0]       alu_op;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic             iord, mem_read, mem_write, ir_write;
   logic             reg_dst, mem_to_reg, reg_write;
   logic [1:0]       pc_src;
   logic             pc_en, illegal;
   logic [CNT_W-1:0] instr_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] e_idle, e_fetch_r, e_fetch_w, e_decode, e_memadr, e_memrd;
   logic [15:0] e_memwb, e_memwr, e_exec, e_aluwb, e_br0, e_br1, e_jump;
   logic [15:0] e_addiwb, e_illeg;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .illegal    (illegal),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic [1:0] aop, input logic sa,
                                      input logic [1:0] sb, input logic io,
                                      input logic mr, input logic mw,
                                      input logic irw, input logic rd,
                                      input logic m2r, input logic rw,
                                      input logic [1:0] ps, input logic pe,
                                      input logic il);
      return {aop, sa, sb, io, mr, mw, irw, rd, m2r, rw, ps, pe, il};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs_vec();
      return {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
              reg_dst, mem_to_reg, reg_write, pc_src, pc_en, illegal};
   endfunction

   // Inputs are set just after a rising edge; outputs checked 1 ns later.
   task automatic step(input string tag, input logic [15:0] exp);
      #1;
      check_eq(tag, {16'h0, obs_vec()}, {16'h0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag, input int exp);
      check_eq(tag, {{(32-CNT_W){1'b0}}, instr_cnt}, exp);
   endtask

   task automatic fetch_decode(input string tag, input logic [5:0] op);
      opcode    = op;
      mem_ready = 1'b1;
      step({tag, "_fetch"},  e_fetch_r);
      step({tag, "_decode"}, e_decode);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      e_idle    = '0;
      e_fetch_r = mk(2'b00,0,2'b01,0,1,0,1,0,0,0,2'b00,1,0);
      e_fetch_w = mk(2'b00,0,2'b01,0,1,0,0,0,0,0,2'b00,0,0);
      e_decode  = mk(2'b00,0,2'b11,0,0,0,0,0,0,0,2'b00,0,0);
      e_memadr  = mk(2'b00,1,2'b10,0,0,0,0,0,0,0,2'b00,0,0);
      e_memrd   = mk(2'b00,0,2'b00,1,1,0,0,0,0,0,2'b00,0,0);
      e_memwb   = mk(2'b00,0,2'b00,0,0,0,0,0,1,1,2'b00,0,0);
      e_memwr   = mk(2'b00,0,2'b00,1,0,1,0,0,0,0,2'b00,0,0);
      e_exec    = mk(2'b10,1,2'b00,0,0,0,0,0,0,0,2'b00,0,0);
      e_aluwb   = mk(2'b00,0,2'b00,0,0,0,0,1,0,1,2'b00,0,0);
      e_br0     = mk(2'b01,1,2'b00,0,0,0,0,0,0,0,2'b01,0,0);
      e_br1     = mk(2'b01,1,2'b00,0,0,0,0,0,0,0,2'b01,1,0);
      e_jump    = mk(2'b00,0,2'b00,0,0,0,0,0,0,0,2'b10,1,0);
      e_addiwb  = mk(2'b00,0,2'b00,0,0,0,0,0,0,1,2'b00,0,0);
      e_illeg   = mk(2'b00,0,2'b00,0,0,0,0,0,0,0,2'b00,0,1);

      rst_n = 1'b0; opcode = 6'b100011; zero = 1'b1; mem_ready = 1'b1;
      #2;
      check_eq("reset_outputs", {16'h0, obs_vec()}, 0);
      check_cnt("reset_cnt", 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_reset_idle", e_idle);

      // lw, memory always ready: 5 cycles, retires once
      fetch_decode("lw", 6'b100011);
      step("lw_memadr", e_memadr);
      step("lw_memrd", e_memrd);
      check_cnt("lw_cnt_before", 0);
      step("lw_memwb", e_memwb);
      check_cnt("lw_cnt_after", 1);

      // fetch stall, then sw with three wait cycles
      opcode = 6'b101011; mem_ready = 1'b0;
      step("fetch_wait", e_fetch_w);
      fetch_decode("sw", 6'b101011);
      step("sw_memadr", e_memadr);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("sw_memwr_wait", e_memwr);
      check_cnt("sw_cnt_waiting", 1);
      mem_ready = 1'b1;
      step("sw_memwr_done", e_memwr);
      check_cnt("sw_cnt_after", 2);

      // beq taken then not taken
      fetch_decode("beq1", 6'b000100);
      zero = 1'b1;
      step("beq_zero1", e_br1);
      check_cnt("beq1_cnt", 3);
      zero = 1'b0;
      fetch_decode("beq0", 6'b000100);
      step("beq_zero0", e_br0);
      check_cnt("beq0_cnt", 4);

      // unsupported opcode
      fetch_decode("ill", 6'b111111);
      step("illeg", e_illeg);
      check_cnt("illeg_cnt", 4);

      // R-type then addi
      fetch_decode("rtype", 6'b000000);
      step("exec", e_exec);
      step("aluwb", e_aluwb);
      check_cnt("rtype_cnt", 5);
      fetch_decode("addi", 6'b001000);
      step("addiex", e_memadr);
      step("addiwb", e_addiwb);
      check_cnt("addi_cnt", 6);

      // jumps up to the counter wrap
      for (int i = 0; i < 10; i++) begin
         fetch_decode("j", 6'b000010);
         step("jump", e_jump);
      end
      check_cnt("wrap_cnt", 0);
      fetch_decode("j_last", 6'b000010);
      step("jump_last", e_jump);
      check_cnt("post_wrap_cnt", 1);

      // reset during a MEMRD wait
      fetch_decode("lw_rst", 6'b100011);
      step("lw_rst_memadr", e_memadr);
      mem_ready = 1'b0;
      step("lw_rst_memrd", e_memrd);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midreset_outputs", {16'h0, obs_vec()}, 0);
      check_cnt("midreset_cnt", 0);
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      rst_n = 1'b1;
      step("release_idle", e_idle);
      step("release_fetch", e_fetch_r);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
